// File: rtl/api_work_arb.sv
`default_nettype none
// ============================================================================
// api_work_arb : packet-atomic round-robin arbiter feeding the api tx_fifo
// Revision     : 1.0
// ============================================================================
module api_work_arb #(
    parameter int NREQ       = 2,
    parameter int WORK_LEN   = 23,
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_flush,
    input  logic [NREQ-1:0]      src_req,
    input  logic [NREQ*32-1:0]   src_dat,
    output logic [NREQ-1:0]      src_pop,
    output logic [NREQ-1:0]      src_abort,
    output logic [NREQ-1:0]      grant,
    input  logic [CNT_W-1:0]     txcnt,
    output logic                 txfifo_push,
    output logic [31:0]          txfifo_din,
    output logic                 busy,
    output logic [15:0]          pkt_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WORK_LEN > 1) ? $clog2(WORK_LEN) : 1;
    localparam logic [CNT_W:0] C_DEPTH     = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0] C_NEED      = (CNT_W+1)'(WORK_LEN + 1);
    localparam logic [CW-1:0]  C_LAST_WORD = CW'(WORK_LEN - 1);
    localparam logic [IW-1:0]  C_LAST_INIT = IW'(NREQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic [NREQ-1:0] r_abort, w_abort_nxt;
    logic [IW-1:0]   r_gidx, w_gidx_nxt;
    logic [IW-1:0]   r_last, w_last_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_push, w_push_nxt;
    logic [31:0]     r_din, w_din_nxt;
    logic [15:0]     r_pkt_cnt, w_pkt_nxt;

    logic [CNT_W:0]  w_free;
    logic            w_space_ok;
    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [31:0]     w_gdat;

    // The +1 reserves room for the registered push that txcnt has not counted yet.
    assign w_free     = C_DEPTH - {1'b0, txcnt};
    assign w_space_ok = (w_free >= C_NEED);

    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && src_req[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_sel   = IW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_gdat = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gidx == IW'(i)) begin
                w_gdat = src_dat[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_abort_nxt = '0;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_push_nxt  = 1'b0;
        w_din_nxt   = r_din;
        w_pkt_nxt   = r_pkt_cnt;
        src_pop     = '0;
        if (reg_flush) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_pkt_nxt   = 16'd0;
            if (r_state == XFER) begin
                w_abort_nxt = r_grant;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found && w_space_ok) begin
                        w_state_nxt = XFER;
                        w_gidx_nxt  = w_sel;
                        w_cnt_nxt   = '0;
                        for (int i = 0; i < NREQ; i++) begin
                            w_grant_nxt[i] = (w_sel == IW'(i));
                        end
                    end
                end
                XFER: begin
                    src_pop    = r_grant;
                    w_push_nxt = 1'b1;
                    w_din_nxt  = w_gdat;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == C_LAST_WORD) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_last_nxt  = r_gidx;
                        w_pkt_nxt   = r_pkt_cnt + 16'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_abort   <= '0;
            r_gidx    <= '0;
            r_last    <= C_LAST_INIT;
            r_cnt     <= '0;
            r_push    <= 1'b0;
            r_din     <= 32'd0;
            r_pkt_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_abort   <= w_abort_nxt;
            r_gidx    <= w_gidx_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_push    <= w_push_nxt;
            r_din     <= w_din_nxt;
            r_pkt_cnt <= w_pkt_nxt;
        end
    end

    assign grant       = r_grant;
    assign src_abort   = r_abort;
    assign txfifo_push = r_push;
    assign txfifo_din  = r_din;
    assign pkt_cnt     = r_pkt_cnt;
    assign busy        = (r_state == XFER) || r_push;

endmodule
`default_nettype wire

// File: tb/tb_api_work_arb.sv
`default_nettype none
// ============================================================================
// tb_api_work_arb : scoreboard bench for api_work_arb with modelled work sources
// Revision        : 1.0
// ============================================================================
module tb_api_work_arb;

    localparam int NREQ     = 2;
    localparam int WORK_LEN = 23;
    localparam int CNT_W    = 11;

    logic               clk = 1'b0;
    logic               rst;
    logic               reg_flush;
    logic [NREQ-1:0]    src_req;
    logic [NREQ*32-1:0] src_dat;
    logic [NREQ-1:0]    src_pop;
    logic [NREQ-1:0]    src_abort;
    logic [NREQ-1:0]    grant;
    logic [CNT_W-1:0]   txcnt;
    logic               txfifo_push;
    logic [31:0]        txfifo_din;
    logic               busy;
    logic [15:0]        pkt_cnt;

    api_work_arb #(.NREQ(NREQ), .WORK_LEN(WORK_LEN), .FIFO_DEPTH(1024), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .reg_flush(reg_flush),
        .src_req(src_req), .src_dat(src_dat), .src_pop(src_pop), .src_abort(src_abort),
        .grant(grant), .txcnt(txcnt), .txfifo_push(txfifo_push), .txfifo_din(txfifo_din),
        .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] expq[$];

    // Source model: req counts packets offered, done counts packets fully popped.
    int req  [NREQ];
    int done [NREQ];
    int ptr  [NREQ];
    int seq  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            src_req[i]          = (req[i] != done[i]);
            src_dat[32*i +: 32] = 32'h100 * (i + 1) + 32'h1000 * seq[i] + ptr[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                ptr[i] <= 0;
            end else if (src_abort[i]) begin
                ptr[i] <= 0;
                seq[i] <= seq[i] + 1;
            end else if (src_pop[i]) begin
                if (ptr[i] == WORK_LEN - 1) begin
                    ptr[i]  <= 0;
                    seq[i]  <= seq[i] + 1;
                    done[i] <= done[i] + 1;
                end else begin
                    ptr[i] <= ptr[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_pkt(input int i, input int s, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            expq.push_back(32'h100 * (i + 1) + 32'h1000 * s + k);
        end
    endtask

    logic prev_push = 1'b0;
    always @(negedge clk) begin
        if (txfifo_push) begin
            if (expq.size() == 0) begin
                chk("unexpected_push", txfifo_din, 32'hFFFF_FFFF);
            end else begin
                chk("push_din", txfifo_din, expq.pop_front());
            end
            if (txfifo_din[7:0] != 8'd0) begin
                chk("push_gap", {31'd0, prev_push}, 32'd1);
            end
        end
        prev_push = txfifo_push;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit hit = 1'b0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            @(negedge clk);
            if (!busy && src_req == '0) hit = 1'b1;
        end
        if (!hit) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_word(input string name, input int src, input int word);
        bit hit = 1'b0;
        for (int n = 0; n < 500 && !hit; n++) begin
            @(negedge clk);
            if (grant[src] && ptr[src] == word) hit = 1'b1;
        end
        if (!hit) chk({name, "_word_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        rst       = 1'b1;
        reg_flush = 1'b0;
        txcnt     = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_pop",   {30'd0, src_pop}, 32'd0);
        chk("rst_abort", {30'd0, src_abort}, 32'd0);
        chk("rst_push",  {31'd0, txfifo_push}, 32'd0);
        chk("rst_din",   txfifo_din, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_pkt",   {16'd0, pkt_cnt}, 32'd0);

        // T1: single packet from src0, latency check
        exp_pkt(0, seq[0], WORK_LEN);
        rst = 1'b0;
        req[0]++;
        @(negedge clk);
        chk("t1_grant_c1", {30'd0, grant}, 32'd1);
        chk("t1_push_c1",  {31'd0, txfifo_push}, 32'd0);
        @(negedge clk);
        chk("t1_push_c2",  {31'd0, txfifo_push}, 32'd1);
        wait_idle("t1");
        chk("t1_pkt", {16'd0, pkt_cnt}, 32'd1);
        chk("t1_q", expq.size(), 32'd0);

        // T2: both requesting, order 0,1,0
        do_reset();
        s0 = seq[0]; s1 = seq[1];
        exp_pkt(0, s0, WORK_LEN);
        exp_pkt(1, s1, WORK_LEN);
        exp_pkt(0, s0 + 1, WORK_LEN);
        req[0] += 2; req[1] += 1;
        wait_idle("t2");
        chk("t2_pkt", {16'd0, pkt_cnt}, 32'd3);
        chk("t2_q", expq.size(), 32'd0);

        // T3: fifo space boundary
        do_reset();
        txcnt = 11'd1001;
        exp_pkt(0, seq[0], WORK_LEN);
        req[0]++;
        repeat (5) @(negedge clk);
        chk("t3_nogrant", {30'd0, grant}, 32'd0);
        chk("t3_nobusy",  {31'd0, busy}, 32'd0);
        txcnt = 11'd1000;
        @(negedge clk);
        chk("t3_grant", {30'd0, grant}, 32'd1);
        wait_idle("t3");
        txcnt = '0;
        chk("t3_q", expq.size(), 32'd0);

        // T4: flush at word 10 of a src1 packet
        do_reset();
        exp_pkt(0, seq[0], WORK_LEN);
        exp_pkt(1, seq[1], 10);
        req[0]++; req[1]++;
        wait_word("t4", 1, 10);
        chk("t4_pre_pkt", {16'd0, pkt_cnt}, 32'd1);
        reg_flush = 1'b1;
        req[1]    = done[1];
        @(negedge clk);
        reg_flush = 1'b0;
        chk("t4_abort", {30'd0, src_abort}, 32'd2);
        chk("t4_push",  {31'd0, txfifo_push}, 32'd0);
        chk("t4_grant", {30'd0, grant}, 32'd0);
        chk("t4_pkt",   {16'd0, pkt_cnt}, 32'd0);
        @(negedge clk);
        chk("t4_abort_end", {30'd0, src_abort}, 32'd0);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        chk("t4_q", expq.size(), 32'd0);

        // T5: pkt_cnt wrap
        do_reset();
        force dut.r_pkt_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_pkt_cnt;
        @(negedge clk);
        chk("t5_preload", {16'd0, pkt_cnt}, 32'h0000_FFFF);
        exp_pkt(0, seq[0], WORK_LEN);
        req[0]++;
        wait_idle("t5");
        chk("t5_wrap", {16'd0, pkt_cnt}, 32'd0);
        chk("t5_q", expq.size(), 32'd0);

        // T6: reset mid-transfer restores src0 priority
        do_reset();
        exp_pkt(0, seq[0], WORK_LEN);
        req[0]++;
        wait_idle("t6a");
        s0 = seq[0]; s1 = seq[1];
        exp_pkt(1, s1, 5);
        exp_pkt(0, s0, WORK_LEN);
        exp_pkt(1, s1, WORK_LEN);
        req[0]++; req[1]++;
        wait_word("t6", 1, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_grant", {30'd0, grant}, 32'd0);
        chk("t6_push",  {31'd0, txfifo_push}, 32'd0);
        chk("t6_busy",  {31'd0, busy}, 32'd0);
        chk("t6_pkt",   {16'd0, pkt_cnt}, 32'd0);
        chk("t6_pop",   {30'd0, src_pop}, 32'd0);
        chk("t6_abort", {30'd0, src_abort}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_prio", {30'd0, grant}, 32'd1);
        wait_idle("t6b");
        chk("t6_pkt_end", {16'd0, pkt_cnt}, 32'd2);
        chk("t6_q", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
